// File: rtl/mem_sram_bridge_pkg.sv
// rtl/mem_sram_bridge_pkg.sv - shared types and constants for the MEM-stage SRAM bridge
package mem_sram_bridge_pkg;

    localparam int DEFAULT_ADDR_W          = 32;
    localparam int DEFAULT_DATA_W          = 32;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    // One in-flight transaction: direction, and whether its response must be dropped.
    typedef struct packed {
        logic we;
        logic discard;
    } tag_t;

endpackage

// File: rtl/mem_sram_bridge_if.sv
// rtl/mem_sram_bridge_if.sv - SRAM-like data-side bus between the bridge and the arbiter
interface mem_sram_bridge_if
    import mem_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic                  req;
    logic                  wr;
    logic [DATA_W/8-1:0]   select;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, select, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, select, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_tag_fifo.sv
// rtl/mem_tag_fifo.sv - in-order tag FIFO with a one-shot "discard everything in flight" input
module mem_tag_fifo
    import mem_sram_bridge_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_MAX_OUTSTANDING,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_we,
    input  logic          pop,
    input  logic          mark_discard,
    output tag_t          head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    tag_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Marking stale slots too is harmless: a later push overwrites the whole entry.
            if (mark_discard) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i].discard <= 1'b1;
                end
            end
            if (push) begin
                mem[wr_ptr] <= '{we: push_we, discard: 1'b0};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_sram_bridge.sv
// rtl/mem_sram_bridge.sv - MEM-stage to SRAM-like bus bridge with in-order, flush-aware responses
module mem_sram_bridge
    import mem_sram_bridge_pkg::*;
#(
    parameter int ADDR_W          = DEFAULT_ADDR_W,
    parameter int DATA_W          = DEFAULT_DATA_W,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                cpu_valid,
    input  logic                cpu_we,
    input  logic [DATA_W/8-1:0] cpu_sel,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_ready,
    output logic                rsp_valid,
    output logic                rsp_we,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy,
    output logic                proto_err,
    mem_sram_bridge_if.master   bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    tag_t          head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          pop;

    assign bus.wr     = cpu_we;
    assign bus.select = cpu_sel;
    assign bus.addr   = cpu_addr;
    assign bus.wdata  = cpu_wdata;

    // Gated on the current count only, so a same-cycle pop never lets a request through when full.
    assign bus.req   = cpu_valid && !full && !flush;
    assign accept    = bus.req && bus.addr_ok;
    assign cpu_ready = accept;

    // The arbiter is flush-unaware, so a data_ok during flush still retires the head.
    assign pop       = bus.data_ok && !empty;
    assign rsp_valid = pop && !head.discard && !flush;
    assign rsp_we    = head.we;
    assign rsp_rdata = bus.rdata;
    assign busy      = (count != '0);

    mem_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (accept),
        .push_we      (cpu_we),
        .pop          (pop),
        .mark_discard (flush),
        .head         (head),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (bus.data_ok && empty) begin
            proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_sram_bridge.sv
// tb/tb_mem_sram_bridge.sv - scoreboard bench for mem_sram_bridge
module tb_mem_sram_bridge;
    localparam int MAXO = 4;

    typedef struct { bit we; bit dis; } ot_t;
    typedef struct { bit we; logic [31:0] rdata; } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, cpu_valid, cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ready, rsp_valid, rsp_we, busy, proto_err;
    logic [31:0] rsp_rdata;

    int tests = 0;
    int fails = 0;

    ot_t  ot_q[$];
    exp_t exp_q[$];
    bit   proto_m = 1'b0;

    mem_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_sram_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cpu_valid (cpu_valid),
        .cpu_we    (cpu_we),
        .cpu_sel   (cpu_sel),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .rsp_valid (rsp_valid),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .proto_err (proto_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, predict, check at negedge, then advance the model.
    task automatic cyc(input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit aok, input bit dok, input logic [31:0] rd, input bit fl, input bit r);
        bit          exp_req;
        logic [3:0]  sel;
        @(posedge clk);
        #1;
        sel = 4'($urandom);
        rst = r; flush = fl; cpu_valid = v; cpu_we = we; cpu_sel = sel;
        cpu_addr = a; cpu_wdata = wd;
        bus.addr_ok = aok; bus.data_ok = dok; bus.rdata = rd;
        exp_req = v && (ot_q.size() < MAXO) && !fl;
        if (!r && dok && ot_q.size() > 0 && !ot_q[0].dis && !fl)
            exp_q.push_back('{we: ot_q[0].we, rdata: rd});
        @(negedge clk);
        chk("req", 128'(bus.req), 128'(exp_req));
        chk("cpu_ready", 128'(cpu_ready), 128'(exp_req && aok));
        chk("busy", 128'(busy), 128'(ot_q.size() != 0));
        chk("proto_err", 128'(proto_err), 128'(proto_m));
        chk("passthru", 128'({bus.wr, bus.select, bus.addr, bus.wdata}), 128'({we, sel, a, wd}));
        if (r) begin
            ot_q.delete();
            proto_m = 1'b0;
        end else begin
            if (dok) begin
                if (ot_q.size() > 0) void'(ot_q.pop_front());
                else proto_m = 1'b1;
            end
            if (fl) foreach (ot_q[i]) ot_q[i].dis = 1'b1;
            if (exp_req && aok) ot_q.push_back('{we: we, dis: 1'b0});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Response monitor: independent of stimulus, consumes the expected-response queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || exp_q.size() != 0) begin
                tests++;
                if (rsp_valid !== 1'b1) begin
                    fails++;
                    e = exp_q.pop_front();
                    $display("FAIL rsp_missing: got rsp_valid=%b expected 1 (we=%b) at %0t", rsp_valid, e.we, $time);
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_we !== e.we || (!e.we && rsp_rdata !== e.rdata)) begin
                        fails++;
                        $display("FAIL rsp_data: got we=%b rdata=%h expected we=%b rdata=%h at %0t",
                                 rsp_we, rsp_rdata, e.we, e.rdata, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_sel = '0;
        cpu_addr = '0; cpu_wdata = '0;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Single read
        cyc(1, 0, 32'h1000, 0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        idle(1);

        // Back-to-back to full, one retire reopens the request path
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h2000 + 4 * i, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 32'h2010, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h11111111, 0, 0);
        cyc(1, 0, 32'h2010, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 32'hA0 + i, 0, 0);
        idle(1);

        // Flush with two reads in flight, then one write
        cyc(1, 0, 32'h3000, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 32'h3004, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 32'h3008, 32'h55, 1, 0, 0, 1, 0);
        cyc(1, 1, 32'h3008, 32'h55, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 32'hB0 + i, 0, 0);
        idle(1);

        // Flush colliding with data_ok and cpu_valid
        cyc(1, 0, 32'h4000, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 32'h4004, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 32'h4008, 0, 1, 1, 32'hC0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hC1, 0, 0);
        idle(1);

        // Simultaneous push and pop at count 2: R, W, R
        cyc(1, 0, 32'h5000, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 32'h5004, 32'h77, 1, 0, 0, 0, 0);
        cyc(1, 0, 32'h5008, 0, 1, 1, 32'hD0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hD1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hD2, 0, 0);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit dok;
            dok = (ot_q.size() > 0) && ($urandom_range(0, 9) < 4);
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom,
                $urandom_range(0, 9) < 7, dok, $urandom, $urandom_range(0, 15) == 0, 0);
        end
        while (ot_q.size() > 0) cyc(0, 0, 0, 0, 0, 1, $urandom, 0, 0);
        idle(1);

        // Reset mid-transaction
        cyc(1, 0, 32'h6000, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Orphan data_ok sets sticky proto_err until reset
        cyc(0, 0, 0, 0, 0, 1, 32'hE0, 0, 0);
        idle(3);
        cyc(1, 1, 32'h7000, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hE1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
